// File: rtl/cajero_pkg.sv
// rtl/cajero_pkg.sv - shared denominations, state encoding and helpers for the bill dispenser
package cajero_pkg;

    localparam int N_DENOM = 4;

    // Cassette order is largest bill first so a greedy plan walks index 0..3.
    localparam int unsigned DEN [N_DENOM] = '{1000, 500, 200, 100};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PLAN,
        ST_EJECT,
        ST_WAIT_ACK,
        ST_DONE,
        ST_ERROR
    } disp_state_t;

    // Index of the largest-denomination cassette that still has bills planned.
    function automatic logic [1:0] lowest_set(input logic [N_DENOM-1:0] v);
        lowest_set = 2'd0;
        for (int i = N_DENOM - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = 2'(i);
        end
    endfunction

endpackage

// File: rtl/denom_cassette.sv
// rtl/denom_cassette.sv - one cassette bill inventory with saturating reload and decrement
module denom_cassette #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [CNT_W-1:0] load_cnt,
    input  logic             dec_en,
    output logic [CNT_W-1:0] inv
);

    logic [CNT_W-1:0] inv_q, inv_d;
    logic [CNT_W:0]   sum;

    // Reload saturates at the counter maximum; decrement never wraps below zero.
    always_comb begin
        inv_d = inv_q;
        sum   = {1'b0, inv_q} + {1'b0, load_cnt};
        if (load_en) begin
            inv_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        end else if (dec_en && (inv_q != '0)) begin
            inv_d = inv_q - CNT_W'(1);
        end
    end

    // Inventory register.
    always_ff @(posedge clk) begin
        if (reset) inv_q <= '0;
        else       inv_q <= inv_d;
    end

    assign inv = inv_q;

endmodule

// File: rtl/cash_dispense_ctrl.sv
// rtl/cash_dispense_ctrl.sv - plans a greedy bill breakdown and drives the ejection motor bill by bill
module cash_dispense_ctrl
    import cajero_pkg::*;
#(
    parameter int MONTO_W     = 32,
    parameter int CNT_W       = 10,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               Entregar_dinero,
    input  logic [MONTO_W-1:0] Monto,
    input  logic               Carga_STB,
    input  logic [1:0]         Carga_cassette,
    input  logic [CNT_W-1:0]   Carga_cant,
    input  logic               Billete_ack,
    output logic               Expulsar,
    output logic [1:0]         Cassette_sel,
    output logic               Ocupado,
    output logic               Dispensado,
    output logic               Error_dispensa,
    output logic [MONTO_W-1:0] Restante
);

    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    disp_state_t                   state_q, state_d;
    logic [1:0]                    d_q, d_d;
    logic [1:0]                    sel_q, sel_d;
    logic [MONTO_W-1:0]            rem_q, rem_d;
    logic [MONTO_W-1:0]            restante_q, restante_d;
    logic [MONTO_W-1:0]            quot;
    logic [N_DENOM-1:0][CNT_W-1:0] n_q, n_d;
    logic [N_DENOM-1:0][CNT_W-1:0] inv;
    logic [CNT_W-1:0]              take;
    logic [TMO_W-1:0]              tmo_q, tmo_d;
    logic [N_DENOM-1:0]            load_en, dec_en, nz;

    for (genvar i = 0; i < N_DENOM; i++) begin : g_cas
        denom_cassette #(.CNT_W(CNT_W)) u_cas (
            .clk      (CLK),
            .reset    (Reset),
            .load_en  (load_en[i]),
            .load_cnt (Carga_cant),
            .dec_en   (dec_en[i]),
            .inv      (inv[i])
        );
    end

    // Next-state logic: plan one denomination per cycle, then hand bills to the motor one at a time.
    always_comb begin
        state_d    = state_q;
        d_d        = d_q;
        sel_d      = sel_q;
        rem_d      = rem_q;
        restante_d = restante_q;
        n_d        = n_q;
        tmo_d      = tmo_q;
        load_en    = '0;
        dec_en     = '0;
        nz         = '0;
        quot       = '0;
        take       = '0;
        case (state_q)
            ST_IDLE: begin
                if (Carga_STB) load_en[Carga_cassette] = 1'b1;
                if (Entregar_dinero) begin
                    rem_d      = Monto;
                    restante_d = Monto;
                    d_d        = 2'd0;
                    n_d        = '0;
                    state_d    = ST_PLAN;
                end
            end
            ST_PLAN: begin
                case (d_q)
                    2'd0:    quot = rem_q / MONTO_W'(DEN[0]);
                    2'd1:    quot = rem_q / MONTO_W'(DEN[1]);
                    2'd2:    quot = rem_q / MONTO_W'(DEN[2]);
                    default: quot = rem_q / MONTO_W'(DEN[3]);
                endcase
                take     = (quot < MONTO_W'(inv[d_q])) ? CNT_W'(quot) : inv[d_q];
                n_d[d_q] = take;
                rem_d    = rem_q - MONTO_W'(take) * MONTO_W'(DEN[d_q]);
                d_d      = d_q + 2'd1;
                if (d_q == 2'd3) begin
                    // The first bill request is issued straight from the last plan step.
                    for (int i = 0; i < N_DENOM; i++) nz[i] = (n_d[i] != '0);
                    if (rem_d != '0) begin
                        state_d = ST_ERROR;
                    end else if (nz != '0) begin
                        sel_d   = lowest_set(nz);
                        tmo_d   = '0;
                        state_d = ST_WAIT_ACK;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_EJECT: begin
                for (int i = 0; i < N_DENOM; i++) nz[i] = (n_q[i] != '0);
                if (nz != '0) begin
                    sel_d   = lowest_set(nz);
                    tmo_d   = '0;
                    state_d = ST_WAIT_ACK;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_WAIT_ACK: begin
                // An ack on the last allowed cycle still counts as a delivered bill.
                if (Billete_ack) begin
                    n_d[sel_q]    = n_q[sel_q] - CNT_W'(1);
                    dec_en[sel_q] = 1'b1;
                    restante_d    = restante_q - MONTO_W'(DEN[sel_q]);
                    state_d       = ST_EJECT;
                end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
                    state_d = ST_ERROR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ERROR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Controller state registers.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            d_q        <= '0;
            sel_q      <= '0;
            rem_q      <= '0;
            restante_q <= '0;
            n_q        <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            d_q        <= d_d;
            sel_q      <= sel_d;
            rem_q      <= rem_d;
            restante_q <= restante_d;
            n_q        <= n_d;
            tmo_q      <= tmo_d;
        end
    end

    assign Expulsar       = (state_q == ST_WAIT_ACK);
    assign Cassette_sel   = sel_q;
    assign Ocupado        = (state_q != ST_IDLE);
    assign Dispensado     = (state_q == ST_DONE);
    assign Error_dispensa = (state_q == ST_ERROR);
    assign Restante       = restante_q;

endmodule

// File: tb/tb_cash_dispense_ctrl.sv
// tb/tb_cash_dispense_ctrl.sv - scoreboard bench for the bill dispenser controller
module tb_cash_dispense_ctrl;

    localparam int MONTO_W     = 32;
    localparam int CNT_W       = 10;
    localparam int ACK_TIMEOUT = 255;

    localparam logic [1:0] EV_BILL = 2'd0;
    localparam logic [1:0] EV_DONE = 2'd1;
    localparam logic [1:0] EV_ERR  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] val;
    } ev_t;

    logic               CLK = 1'b0;
    logic               Reset = 1'b1;
    logic               Entregar_dinero = 1'b0;
    logic [MONTO_W-1:0] Monto = '0;
    logic               Carga_STB = 1'b0;
    logic [1:0]         Carga_cassette = '0;
    logic [CNT_W-1:0]   Carga_cant = '0;
    logic               Billete_ack = 1'b0;
    logic               Expulsar;
    logic [1:0]         Cassette_sel;
    logic               Ocupado;
    logic               Dispensado;
    logic               Error_dispensa;
    logic [MONTO_W-1:0] Restante;

    int  n_chk = 0;
    int  n_pass = 0;
    ev_t exp_q[$];
    logic auto_ack = 1'b0;
    int  last_run = 0;

    cash_dispense_ctrl #(
        .MONTO_W(MONTO_W), .CNT_W(CNT_W), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .CLK(CLK), .Reset(Reset), .Entregar_dinero(Entregar_dinero), .Monto(Monto),
        .Carga_STB(Carga_STB), .Carga_cassette(Carga_cassette), .Carga_cant(Carga_cant),
        .Billete_ack(Billete_ack), .Expulsar(Expulsar), .Cassette_sel(Cassette_sel),
        .Ocupado(Ocupado), .Dispensado(Dispensado), .Error_dispensa(Error_dispensa),
        .Restante(Restante)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic push(input logic [1:0] kind, input logic [31:0] val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic observe(input string name, input logic [1:0] kind, input logic [31:0] val);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk({"sb_unexpected_", name}, 32'(kind), 32'd3);
        end else begin
            e = exp_q.pop_front();
            chk({"sb_kind_", name}, 32'(kind), 32'(e.kind));
            chk({"sb_val_", name}, val, e.val);
        end
    endtask

    // Output monitor: every bill request and completion pulse is matched against the queue.
    initial begin
        logic prev_exp;
        int   run;
        prev_exp = 1'b0;
        run = 0;
        forever begin
            @(negedge CLK);
            if (!Reset) begin
                if (Expulsar && !prev_exp) observe("bill", EV_BILL, 32'(Cassette_sel));
                if (Dispensado)            observe("done", EV_DONE, Restante);
                if (Error_dispensa)        observe("err", EV_ERR, Restante);
            end
            if (Expulsar) run++;
            else if (run != 0) begin
                last_run = run;
                run = 0;
            end
            prev_exp = Expulsar;
        end
    end

    // Motor model: acknowledge on the second cycle of each request while enabled.
    initial begin
        int hi_cnt;
        hi_cnt = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (auto_ack && Expulsar) begin
                hi_cnt++;
                Billete_ack = (hi_cnt == 2);
            end else begin
                hi_cnt = 0;
                Billete_ack = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input int c, input int cnt);
        step();
        Carga_STB = 1'b1;
        Carga_cassette = 2'(c);
        Carga_cant = CNT_W'(cnt);
        step();
        Carga_STB = 1'b0;
    endtask

    task automatic start(input int m);
        step();
        Entregar_dinero = 1'b1;
        Monto = 32'(m);
        step();
        Entregar_dinero = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int k;
        k = 0;
        @(negedge CLK);
        while (Ocupado && k < limit) begin
            @(negedge CLK);
            k++;
        end
        chk("wait_idle", 32'(Ocupado), 32'd0);
    endtask

    task automatic wait_exp(input int limit);
        int k;
        k = 0;
        @(negedge CLK);
        while (!Expulsar && k < limit) begin
            @(negedge CLK);
            k++;
        end
        chk("wait_expulsar", 32'(Expulsar), 32'd1);
    endtask

    task automatic chk_inv(input string tag, input int i0, input int i1, input int i2, input int i3);
        chk({tag, "_inv0"}, 32'(dut.inv[0]), 32'(i0));
        chk({tag, "_inv1"}, 32'(dut.inv[1]), 32'(i1));
        chk({tag, "_inv2"}, 32'(dut.inv[2]), 32'(i2));
        chk({tag, "_inv3"}, 32'(dut.inv[3]), 32'(i3));
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1 Reset = 1'b0;
        @(negedge CLK);
        chk("rst_ocupado", 32'(Ocupado), 32'd0);
        chk("rst_expulsar", 32'(Expulsar), 32'd0);
        chk("rst_dispensado", 32'(Dispensado), 32'd0);
        chk("rst_error", 32'(Error_dispensa), 32'd0);
        chk("rst_restante", Restante, 32'd0);
        chk_inv("rst", 0, 0, 0, 0);

        // Full greedy breakdown across all four cassettes.
        auto_ack = 1'b1;
        for (int c = 0; c < 4; c++) load(c, 5);
        for (int c = 0; c < 4; c++) push(EV_BILL, 32'(c));
        push(EV_DONE, 32'd0);
        start(1800);
        repeat (5) @(negedge CLK);
        chk("t1_first_expulsar", 32'(Expulsar), 32'd1);
        chk("t1_first_sel", 32'(Cassette_sel), 32'd0);
        wait_idle(200);
        chk_inv("t1", 4, 4, 4, 4);
        chk("t1_restante", Restante, 32'd0);

        // Reset in the middle of a bill request.
        auto_ack = 1'b0;
        push(EV_BILL, 32'd0);
        start(1000);
        wait_exp(20);
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        @(negedge CLK);
        chk("t5_expulsar", 32'(Expulsar), 32'd0);
        chk("t5_ocupado", 32'(Ocupado), 32'd0);
        chk("t5_restante", Restante, 32'd0);
        chk_inv("t5", 0, 0, 0, 0);
        repeat (10) @(negedge CLK);

        // Greedy plan failure leaves inventory untouched.
        load(1, 1);
        load(2, 3);
        push(EV_ERR, 32'd600);
        start(600);
        repeat (5) @(negedge CLK);
        chk("t2_error_t5", 32'(Error_dispensa), 32'd1);
        chk("t2_expulsar", 32'(Expulsar), 32'd0);
        wait_idle(20);
        chk_inv("t2", 0, 1, 3, 0);

        // Amount that is not a multiple of the smallest bill.
        push(EV_ERR, 32'd150);
        start(150);
        repeat (5) @(negedge CLK);
        chk("t3_error_t5", 32'(Error_dispensa), 32'd1);
        chk("t3_restante", Restante, 32'd150);
        wait_idle(20);

        // Motor never acknowledges: request held for the full timeout.
        load(0, 2);
        push(EV_BILL, 32'd0);
        push(EV_ERR, 32'd2000);
        start(2000);
        wait_idle(ACK_TIMEOUT + 50);
        chk("t4_expulsar_len", 32'(last_run), 32'(ACK_TIMEOUT));
        chk("t4_inv0", 32'(dut.inv[0]), 32'd2);
        chk("t4_restante", Restante, 32'd2000);

        // Start and reload strobes are ignored while busy.
        push(EV_BILL, 32'd0);
        push(EV_DONE, 32'd0);
        start(1000);
        wait_exp(20);
        step();
        Entregar_dinero = 1'b1;
        Monto = 32'd500;
        Carga_STB = 1'b1;
        Carga_cassette = 2'd3;
        Carga_cant = CNT_W'(7);
        step();
        Entregar_dinero = 1'b0;
        Carga_STB = 1'b0;
        @(negedge CLK);
        chk("t6_ocupado", 32'(Ocupado), 32'd1);
        chk("t6_restante_busy", Restante, 32'd1000);
        chk("t6_inv3_busy", 32'(dut.inv[3]), 32'd0);
        auto_ack = 1'b1;
        wait_idle(50);
        chk("t6_inv0", 32'(dut.inv[0]), 32'd1);
        chk("t6_inv3", 32'(dut.inv[3]), 32'd0);

        // Zero amount completes with no bills.
        push(EV_DONE, 32'd0);
        start(0);
        repeat (5) @(negedge CLK);
        chk("t6_zero_done_t5", 32'(Dispensado), 32'd1);
        chk("t6_zero_expulsar", 32'(Expulsar), 32'd0);
        wait_idle(20);

        repeat (5) @(negedge CLK);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
